// File: rtl/spi_fwm_rxf_ctrl_pkg.sv
// Shared types for the SPI flash/passthrough RX FIFO-to-SRAM writer.
// State encoding and pointer-width helper.
package spi_fwm_rxf_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StRead,
    StLatch,
    StWrite,
    StUpdate
  } rxf_st_e;

  localparam int unsigned FifoDwDef = 8;
  localparam int unsigned SramAwDef = 11;
  localparam int unsigned SramDwDef = 32;
  localparam int unsigned TimerWDef = 8;

  function automatic int unsigned ptr_w(
    input int unsigned aw,
    input int unsigned sdw
  );
    return aw + sdw + 1;
  endfunction

endpackage

// File: rtl/spi_fwm_rxf_ctrl.sv
// Packs RX FIFO bytes into SRAM words, flushing partial words after
// an idle timeout with a read-modify-write of the untouched lanes.
module spi_fwm_rxf_ctrl
  import spi_fwm_rxf_ctrl_pkg::*;
#(
  parameter int unsigned FifoDw   = FifoDwDef,
  parameter int unsigned SramAw   = SramAwDef,
  parameter int unsigned SramDw   = SramDwDef,
  parameter int unsigned NumBytes = SramDw / FifoDw,
  parameter int unsigned SDW      = $clog2(NumBytes),
  parameter int unsigned PtrW     = ptr_w(SramAw, SDW),
  parameter int unsigned TimerW   = TimerWDef
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [SramAw-1:0] base_index_i,
  input  logic [SramAw-1:0] limit_index_i,
  input  logic [TimerW-1:0] timer_v,
  input  logic              abort,
  input  logic [PtrW-1:0]   rptr,
  output logic [PtrW-1:0]   wptr,
  output logic [PtrW-1:0]   depth,
  input  logic              fifo_valid,
  output logic              fifo_ready,
  input  logic [FifoDw-1:0] fifo_rdata,
  output logic              sram_req,
  output logic              sram_write,
  output logic [SramAw-1:0] sram_addr,
  output logic [SramDw-1:0] sram_wdata,
  input  logic              sram_gnt,
  input  logic              sram_rvalid,
  input  logic [SramDw-1:0] sram_rdata,
  input  logic [1:0]        sram_error
);

  rxf_st_e st_q, st_d;

  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [SDW-1:0]      pos_q, pos_d;
  logic [NumBytes-1:0] mask_q, mask_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [SramDw-1:0]   buf_q, buf_d;
  logic                req_q, we_q;

  logic              full;
  logic              accept;
  logic              last;
  logic [SramAw-1:0] idx;
  logic [SramAw-1:0] span;
  logic              unused_err;

  assign unused_err = ^sram_error;

  assign idx  = wptr_q[PtrW-2:SDW];
  assign span = limit_index_i - base_index_i;
  assign full = (wptr_q[PtrW-1] != rptr[PtrW-1]) &&
                (idx == rptr[PtrW-2:SDW]);
  assign last = (pos_q == SDW'(NumBytes - 1));

  // Abort blocks the handshake so no byte is lost on the discard cycle.
  assign fifo_ready = (st_q == StPop) && !abort && !mask_q[pos_q];
  assign accept     = fifo_ready && fifo_valid;

  always_comb begin
    st_d    = st_q;
    wptr_d  = wptr_q;
    pos_d   = pos_q;
    mask_d  = mask_q;
    timer_d = timer_q;
    buf_d   = buf_q;
    unique case (st_q)
      StIdle: begin
        pos_d   = wptr_q[SDW-1:0];
        mask_d  = '0;
        timer_d = '0;
        if (fifo_valid && !full) st_d = StPop;
      end
      StPop: begin
        if (abort) begin
          st_d   = StIdle;
          mask_d = '0;
          buf_d  = '0;
        end else if (accept) begin
          for (int i = 0; i < NumBytes; i++) begin
            if (pos_q == SDW'(i)) buf_d[FifoDw*i +: FifoDw] = fifo_rdata;
          end
          mask_d[pos_q] = 1'b1;
          pos_d         = pos_q + SDW'(1);
          timer_d       = '0;
          if (last) st_d = (&mask_d) ? StWrite : StRead;
        end else begin
          timer_d = timer_q + TimerW'(1);
          if (timer_q == timer_v && |mask_q) st_d = StRead;
        end
      end
      StRead: begin
        if (sram_gnt) st_d = StLatch;
      end
      StLatch: begin
        if (sram_rvalid) begin
          for (int i = 0; i < NumBytes; i++) begin
            if (!mask_q[i]) begin
              buf_d[FifoDw*i +: FifoDw] = sram_rdata[FifoDw*i +: FifoDw];
            end
          end
          st_d = StWrite;
        end
      end
      StWrite: begin
        if (sram_gnt) st_d = StUpdate;
      end
      StUpdate: begin
        st_d = StIdle;
        if (pos_q == '0) begin
          wptr_d[SDW-1:0] = '0;
          if (idx == span) begin
            wptr_d[PtrW-2:SDW] = '0;
            wptr_d[PtrW-1]     = ~wptr_q[PtrW-1];
          end else begin
            wptr_d[PtrW-2:SDW] = idx + SramAw'(1);
          end
        end else begin
          wptr_d[SDW-1:0] = pos_q;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= StIdle;
      wptr_q  <= '0;
      pos_q   <= '0;
      mask_q  <= '0;
      timer_q <= '0;
      buf_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      wptr_q  <= wptr_d;
      pos_q   <= pos_d;
      mask_q  <= mask_d;
      timer_q <= timer_d;
      buf_q   <= buf_d;
      req_q   <= (st_d == StRead) || (st_d == StWrite);
      we_q    <= (st_d == StWrite);
    end
  end

  assign wptr       = wptr_q;
  assign sram_req   = req_q;
  assign sram_write = we_q;
  assign sram_addr  = base_index_i + idx;
  assign sram_wdata = buf_q;

  // Wrapped case counts the tail of the region from rptr plus the head up to wptr.
  always_comb begin
    if (wptr_q[PtrW-1] == rptr[PtrW-1]) begin
      depth = {1'b0, wptr_q[PtrW-2:0]} - {1'b0, rptr[PtrW-2:0]};
    end else begin
      depth = {1'b0, wptr_q[PtrW-2:0]}
            + ({1'b0, span, {SDW{1'b1}}} - {1'b0, rptr[PtrW-2:0]})
            + PtrW'(1);
    end
  end

endmodule

// File: tb/tb_spi_fwm_rxf_ctrl.sv
// Directed vector bench for spi_fwm_rxf_ctrl with a small SRAM model.
// Region is words 0x10..0x13, default widths.
module tb_spi_fwm_rxf_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [10:0] base_index = 11'h10;
  logic [10:0] limit_index = 11'h13;
  logic [7:0]  timer_v;
  logic        abort;
  logic [13:0] rptr;
  logic [13:0] wptr;
  logic [13:0] depth;
  logic        fifo_valid;
  logic        fifo_ready;
  logic [7:0]  fifo_rdata;
  logic        sram_req;
  logic        sram_write;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_gnt;
  logic        sram_rvalid = 1'b0;
  logic [31:0] sram_rdata = '0;
  logic [1:0]  sram_error = 2'b00;

  logic        gnt_en;
  logic        pl_en;
  logic [10:0] pl_addr;
  logic [31:0] pl_data;

  logic [31:0] mem [0:2047];
  logic [2047:0] written = '0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          req_cyc = 0;
  logic [10:0] last_waddr = '0;
  logic [10:0] last_raddr = '0;
  logic [31:0] last_wdata = '0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  spi_fwm_rxf_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .base_index_i (base_index),
    .limit_index_i(limit_index),
    .timer_v      (timer_v),
    .abort        (abort),
    .rptr         (rptr),
    .wptr         (wptr),
    .depth        (depth),
    .fifo_valid   (fifo_valid),
    .fifo_ready   (fifo_ready),
    .fifo_rdata   (fifo_rdata),
    .sram_req     (sram_req),
    .sram_write   (sram_write),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_gnt     (sram_gnt),
    .sram_rvalid  (sram_rvalid),
    .sram_rdata   (sram_rdata),
    .sram_error   (sram_error)
  );

  assign sram_gnt = sram_req & gnt_en;

  // Unwritten words read back as 0xDEADBEEF.
  always @(posedge clk) begin
    sram_rvalid <= 1'b0;
    if (sram_req) req_cyc <= req_cyc + 1;
    if (pl_en) begin
      mem[pl_addr]     <= pl_data;
      written[pl_addr] <= 1'b1;
    end else if (sram_req && sram_gnt) begin
      if (sram_write) begin
        mem[sram_addr]     <= sram_wdata;
        written[sram_addr] <= 1'b1;
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= sram_addr;
        last_wdata <= sram_wdata;
      end else begin
        sram_rvalid <= 1'b1;
        sram_rdata  <= written[sram_addr] ? mem[sram_addr] : 32'hDEADBEEF;
        rd_cnt      <= rd_cnt + 1;
        last_raddr  <= sram_addr;
      end
    end
  end

  typedef struct {
    bit          do_rst;
    bit          pre;
    logic [13:0] rp;
    logic [7:0]  tv;
    int          n;
    logic [31:0] bytes;
    bit          exp_rd;
    logic [10:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [13:0] exp_wptr;
    logic [13:0] exp_depth;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    fifo_valid = 1'b1;
    fifo_rdata = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) @(posedge clk);
    #1 fifo_valid = 1'b0;
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL push_timeout: byte %h not accepted", b);
    end
  endtask

  task automatic wait_wr(input int w0, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_cnt != w0) begin
        ok = 1'b1;
        break;
      end
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL %s_wr_timeout: got no write want one", nm);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic vec_t mk(
    input bit r, input bit p, input logic [13:0] rp,
    input logic [7:0] tv, input int n, input logic [31:0] by,
    input bit erd, input logic [10:0] ea, input logic [31:0] ed,
    input logic [13:0] ew, input logic [13:0] edp);
    vec_t v;
    v.do_rst = r;   v.pre = p;      v.rp = rp;
    v.tv = tv;      v.n = n;        v.bytes = by;
    v.exp_rd = erd; v.exp_addr = ea;
    v.exp_wdata = ed;
    v.exp_wptr = ew; v.exp_depth = edp;
    return v;
  endfunction

  initial begin
    int w0, r0, q0, bad;
    string nm;
    bit ok;

    rst_i = 1'b1; timer_v = 8'd8; abort = 1'b0; rptr = '0;
    fifo_valid = 1'b0; fifo_rdata = '0; gnt_en = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    vt[0] = mk(1, 0, 14'h0, 8'd8, 4, 32'h44332211,
               0, 11'h10, 32'h44332211, 14'h0004, 14'd4);
    vt[1] = mk(1, 1, 14'h0, 8'd3, 2, 32'h0000BBAA,
               1, 11'h10, 32'hDEADBBAA, 14'h0002, 14'd2);
    vt[2] = mk(0, 0, 14'h0, 8'd3, 2, 32'h0000DDCC,
               1, 11'h10, 32'hDDCCBBAA, 14'h0004, 14'd4);
    vt[3] = mk(0, 0, 14'h0, 8'd8, 4, 32'h04030201,
               0, 11'h11, 32'h04030201, 14'h0008, 14'd8);
    vt[4] = mk(0, 0, 14'h0, 8'd8, 4, 32'h08070605,
               0, 11'h12, 32'h08070605, 14'h000C, 14'd12);
    vt[5] = mk(0, 0, 14'h0, 8'd8, 4, 32'h0C0B0A09,
               0, 11'h13, 32'h0C0B0A09, 14'h2000, 14'd16);
    vt[6] = mk(0, 0, 14'h4, 8'd8, 4, 32'hE4E3E2E1,
               0, 11'h10, 32'hE4E3E2E1, 14'h2004, 14'd16);

    // Reset state
    fifo_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wptr", 32'(wptr), 32'h0);
    chk("rst_depth", 32'(depth), 32'h0);
    chk("rst_req", 32'(sram_req), 32'h0);
    chk("rst_ready", 32'(fifo_ready), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h10);
    fifo_valid = 1'b0;
    #1 rst_i = 1'b0;

    for (int v = 0; v < 7; v++) begin
      if (vt[v].do_rst) do_reset();
      if (vt[v].pre) preload(11'h10, 32'hDEADBEEF);
      rptr = vt[v].rp;
      timer_v = vt[v].tv;
      w0 = wr_cnt;
      r0 = rd_cnt;
      for (int b = 0; b < vt[v].n; b++) push(vt[v].bytes[8*b +: 8]);
      nm = $sformatf("v%0d", v);
      wait_wr(w0, nm);
      chk({nm, "_nwr"}, 32'(wr_cnt - w0), 32'd1);
      chk({nm, "_waddr"}, 32'(last_waddr), 32'(vt[v].exp_addr));
      chk({nm, "_wdata"}, last_wdata, vt[v].exp_wdata);
      chk({nm, "_nrd"}, 32'(rd_cnt - r0), vt[v].exp_rd ? 32'd1 : 32'd0);
      if (vt[v].exp_rd) begin
        chk({nm, "_raddr"}, 32'(last_raddr), 32'(vt[v].exp_addr));
      end
      chk({nm, "_wptr"}, 32'(wptr), 32'(vt[v].exp_wptr));
      chk({nm, "_depth"}, 32'(depth), 32'(vt[v].exp_depth));

      // After the wrap, rptr=0 makes the region full.
      if (v == 5) begin
        q0 = req_cyc;
        bad = 0;
        fifo_valid = 1'b1;
        fifo_rdata = 8'h99;
        repeat (10) begin
          @(negedge clk);
          if (fifo_ready) bad++;
        end
        fifo_valid = 1'b0;
        chk("full_ready", 32'(bad), 32'd0);
        chk("full_noreq", 32'(req_cyc - q0), 32'd0);
        chk("full_depth", 32'(depth), 32'd16);
        chk("full_wptr", 32'(wptr), 32'h2000);
      end
    end

    // Abort two bytes into a word
    do_reset();
    rptr = '0;
    timer_v = 8'd50;
    q0 = req_cyc;
    push(8'h55);
    push(8'h66);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    repeat (70) @(negedge clk);
    chk("abort_noreq", 32'(req_cyc - q0), 32'd0);
    chk("abort_wptr", 32'(wptr), 32'h0);
    chk("abort_depth", 32'(depth), 32'h0);

    // Reset while a write is waiting for grant
    gnt_en = 1'b0;
    timer_v = 8'd8;
    w0 = wr_cnt;
    push(8'h71); push(8'h72); push(8'h73); push(8'h74);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sram_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_req_seen", 32'(ok), 32'd1);
    chk("mid_write", 32'(sram_write), 32'd1);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("mid_req_drop", 32'(sram_req), 32'd0);
    chk("mid_wptr", 32'(wptr), 32'h0);
    gnt_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_nwr", 32'(wr_cnt - w0), 32'd0);
    chk("mid_req_idle", 32'(sram_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
